ram_1w_nr: RTL and testbench

Parametrised synchronous RAM with one byte-masked write port and NUM_RD independent read ports. It is the successor to the fixed 64-bit instruction/data RAM model used by the CPU core. It is synthesizable and needs no DPI helpers. It self-initialises to zero after reset, returns read data with a one-cycle registered latency under a valid/ready handshake, and flags out-of-range accesses. It sits between the fetch/LSU stages and backing storage in simulation and FPGA builds.

---
 rtl/ram_1w_nr_pkg.sv | 17 +
 rtl/ram_rd_port.sv | 71 +++++++
 rtl/ram_1w_nr.sv | 119 +++++++++++
 tb/tb_ram_1w_nr.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_1w_nr_pkg.sv
// Shared types and helpers for the ram_1w_nr RAM and its read ports.
// Optional read bypass is selected with the RAM_RD_BYPASS_EN macro.
package ram_1w_nr_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_e;

    localparam logic [63:0] DEFAULT_PC_BASE = 64'h8000_0000;

    // One byte-enable bit widened to a full byte of bit enables.
    function automatic logic [7:0] byte_fill(input logic en);
        return {8{en}};
    endfunction

endpackage

// File: rtl/ram_rd_port.sv
// One read port of ram_1w_nr: address decode, range check, optional
// write bypass (RAM_RD_BYPASS_EN) and the registered response outputs.
module ram_rd_port
    import ram_1w_nr_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_PC_BASE),
    localparam int IDX_W = $clog2(DEPTH),
    localparam int OFF_W = $clog2(DATA_W/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ready_i,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [IDX_W-1:0]  idx_o,
    input  logic [DATA_W-1:0] word_i,
`ifdef RAM_RD_BYPASS_EN
    input  logic              wr_fire_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] wr_bits_i,
`endif
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    logic [ADDR_W-1:0] word_off;
    logic              in_range;
    logic              accept;
    logic [DATA_W-1:0] rd_word;
    logic              valid_q;
    logic              err_q;
    logic [DATA_W-1:0] data_q;

    // Byte-offset bits fall away in the shift, so misaligned addresses are legal.
    assign word_off = (addr_i - BASE_ADDR) >> OFF_W;
    assign idx_o    = word_off[IDX_W-1:0];
    assign in_range = (addr_i >= BASE_ADDR) && (word_off[ADDR_W-1:IDX_W] == '0);
    assign accept   = req_i && ready_i;

`ifdef RAM_RD_BYPASS_EN
    assign rd_word = (wr_fire_i && (wr_idx_i == idx_o))
                   ? ((word_i & ~wr_bits_i) | (wr_data_i & wr_bits_i))
                   : word_i;
`else
    assign rd_word = word_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= accept;
            if (accept) begin
                data_q <= in_range ? rd_word : '0;
                err_q  <= ~in_range;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign err_o   = err_q;

endmodule

// File: rtl/ram_1w_nr.sv
// Byte-masked single-write, NUM_RD-read RAM that zero-fills itself after reset.
// Define RAM_RD_BYPASS_EN to forward same-cycle write data to colliding reads.
module ram_1w_nr
    import ram_1w_nr_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024,
    parameter int NUM_RD = 2,
    parameter int ADDR_W = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_PC_BASE)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     ready,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_err,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [DATA_W/8-1:0]      wr_mask
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(DATA_W/8);
    localparam int NB    = DATA_W/8;

    logic [DATA_W-1:0] mem [DEPTH];

    ram_state_e        state_q;
    logic [IDX_W-1:0]  cnt_q;
    logic              ready_q;

    logic [ADDR_W-1:0] wr_word_off;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_in_range;
    logic              wr_fire;
    logic [DATA_W-1:0] wr_bits;

    logic [IDX_W-1:0]  port_idx  [NUM_RD];
    logic [DATA_W-1:0] port_word [NUM_RD];

    assign wr_word_off = (wr_addr - BASE_ADDR) >> OFF_W;
    assign wr_idx      = wr_word_off[IDX_W-1:0];
    assign wr_in_range = (wr_addr >= BASE_ADDR) && (wr_word_off[ADDR_W-1:IDX_W] == '0);
    assign wr_fire     = wr_en && ready_q && wr_in_range;

    for (genvar gi = 0; gi < NB; gi++) begin : g_bits
        assign wr_bits[gi*8 +: 8] = byte_fill(wr_mask[gi]);
    end

    // ready_q is simply the registered image of being in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(DEPTH-1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset; INIT sweeps it to zero one word per cycle.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= '0;
        end else if (wr_fire) begin
            mem[wr_idx] <= (mem[wr_idx] & ~wr_bits) | (wr_data & wr_bits);
        end
    end

    assign ready = ready_q;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
        assign port_word[gi] = mem[port_idx[gi]];

        ram_rd_port #(
            .DATA_W    (DATA_W),
            .DEPTH     (DEPTH),
            .ADDR_W    (ADDR_W),
            .BASE_ADDR (BASE_ADDR)
        ) u_port (
            .clk       (clk),
            .rst       (rst),
            .ready_i   (ready_q),
            .req_i     (rd_req[gi]),
            .addr_i    (rd_addr[gi*ADDR_W +: ADDR_W]),
            .idx_o     (port_idx[gi]),
            .word_i    (port_word[gi]),
`ifdef RAM_RD_BYPASS_EN
            .wr_fire_i (wr_fire),
            .wr_idx_i  (wr_idx),
            .wr_data_i (wr_data),
            .wr_bits_i (wr_bits),
`endif
            .valid_o   (rd_valid[gi]),
            .data_o    (rd_data[gi*DATA_W +: DATA_W]),
            .err_o     (rd_err[gi])
        );
    end

endmodule

// File: tb/tb_ram_1w_nr.sv
// Self-checking bench for ram_1w_nr (DEPTH=16) against an array-based reference.
// Honours RAM_RD_BYPASS_EN for the same-cycle read/write expectation.
module tb_ram_1w_nr;

    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int NRD   = 2;
    localparam int AW    = 64;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ready;
    logic [NRD-1:0]  rd_req = '0;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD-1:0]  rd_valid;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]  rd_err;
    logic            wr_en = 1'b0;
    logic [AW-1:0]   wr_addr = '0;
    logic [DW-1:0]   wr_data = '0;
    logic [DW/8-1:0] wr_mask = '0;

    always #5 clk = ~clk;

    ram_1w_nr #(
        .DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .ADDR_W(AW), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_err(rd_err),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask)
    );

    logic [63:0] ref_mem [DEPTH];
    logic [63:0] exp_data [NRD];
    logic        exp_err  [NRD];
    int          init_left;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oor(input logic [63:0] a);
        return (a < BASE) || (((a - BASE) / 8) >= 64'(DEPTH));
    endfunction

    function automatic int to_idx(input logic [63:0] a);
        return int'((a - BASE) / 8);
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                          input logic [7:0] m);
        logic [63:0] r;
        r = old_w;
        for (int b = 0; b < 8; b++)
            if (m[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        for (int p = 0; p < NRD; p++) begin
            exp_data[p] = '0;
            exp_err[p]  = 1'b0;
        end
        init_left = DEPTH;
    endtask

    task automatic set_rd(input int p, input logic req, input logic [63:0] a);
        rd_req[p] = req;
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input logic en, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] m);
        wr_en = en; wr_addr = a; wr_data = d; wr_mask = m;
    endtask

    task automatic idle();
        rd_req = '0;
        wr_en  = 1'b0;
    endtask

    // Predict, advance one clock, update the model and compare every output.
    task automatic cycle();
        logic [63:0] pre_d [NRD];
        logic        pre_e [NRD];
        logic        acc   [NRD];
        logic [63:0] a;
        bit          rdy, wacc;
        int          widx;
        rdy  = (init_left == 0);
        wacc = rdy && wr_en && !is_oor(wr_addr);
        widx = wacc ? to_idx(wr_addr) : 0;
        for (int p = 0; p < NRD; p++) begin
            a = rd_addr[p*AW +: AW];
            acc[p] = rdy && rd_req[p];
            pre_d[p] = '0;
            pre_e[p] = 1'b1;
            if (!is_oor(a)) begin
                pre_e[p] = 1'b0;
                pre_d[p] = ref_mem[to_idx(a)];
`ifdef RAM_RD_BYPASS_EN
                if (wacc && widx == to_idx(a)) pre_d[p] = merge(pre_d[p], wr_data, wr_mask);
`endif
            end
        end
        @(posedge clk);
        #1;
        if (init_left > 0) init_left--;
        if (wacc) ref_mem[widx] = merge(ref_mem[widx], wr_data, wr_mask);
        for (int p = 0; p < NRD; p++) begin
            if (acc[p]) begin
                exp_data[p] = pre_d[p];
                exp_err[p]  = pre_e[p];
            end
            chk($sformatf("rd_valid[%0d]", p), 64'(rd_valid[p]), 64'(acc[p]));
            chk($sformatf("rd_data[%0d]", p), rd_data[p*DW +: DW], exp_data[p]);
            chk($sformatf("rd_err[%0d]", p), 64'(rd_err[p]), 64'(exp_err[p]));
        end
        chk("ready", 64'(ready), 64'(init_left == 0));
    endtask

    function automatic logic [63:0] rand_addr();
        return BASE - 64'd16 + 64'($urandom_range(0, DEPTH + 3)) * 8 + 64'($urandom_range(0, 7));
    endfunction

    initial begin
        model_reset();
        // Reset values while rst is held
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", 64'(ready), 64'd0);
        chk("reset rd_valid", 64'(rd_valid), 64'd0);
        chk("reset rd_err", 64'(rd_err), 64'd0);
        chk("reset rd_data0", rd_data[0 +: DW], 64'd0);
        chk("reset rd_data1", rd_data[DW +: DW], 64'd0);
        rst = 1'b0;

        // INIT: requests are ignored, ready stays low for exactly DEPTH cycles
        set_rd(0, 1'b1, BASE);
        set_rd(1, 1'b1, BASE + 64'd8);
        set_wr(1'b1, BASE, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        repeat (DEPTH) cycle();
        idle();

        // Every word reads back zero after INIT; byte offset is ignored
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(0, 1'b1, BASE + 64'(i) * 8);
            set_rd(1, 1'b1, BASE + 64'(i) * 8 + 64'($urandom_range(0, 7)));
            cycle();
        end
        idle();

        // Full-word write then read on port 1
        set_wr(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF);
        cycle();
        idle();
        set_rd(1, 1'b1, 64'h8000_0008);
        cycle();
        chk("full write", rd_data[DW +: DW], 64'h1122_3344_5566_7788);
        idle();

        // Partial-mask write
        set_wr(1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        cycle();
        idle();
        set_rd(1, 1'b1, 64'h8000_0008);
        cycle();
        chk("partial write", rd_data[DW +: DW], 64'h1122_3344_FFFF_FFFF);
        idle();

        // Zero mask is a no-op
        set_wr(1'b1, 64'h8000_0008, 64'h0, 8'h00);
        cycle();
        idle();
        set_rd(0, 1'b1, 64'h8000_0008);
        cycle();
        chk("zero mask", rd_data[0 +: DW], 64'h1122_3344_FFFF_FFFF);
        idle();

        // Same-cycle write and read of a zero word
        set_wr(1'b1, BASE + 64'd16, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
        set_rd(0, 1'b1, BASE + 64'd16);
        cycle();
`ifdef RAM_RD_BYPASS_EN
        chk("rd during wr", rd_data[0 +: DW], 64'hA5A5_A5A5_A5A5_A5A5);
`else
        chk("rd during wr", rd_data[0 +: DW], 64'h0);
`endif
        idle();
        set_rd(0, 1'b1, BASE + 64'd16);
        cycle();
        chk("wr next cycle", rd_data[0 +: DW], 64'hA5A5_A5A5_A5A5_A5A5);
        idle();

        // Out-of-range reads on both sides, and a dropped out-of-range write
        set_rd(0, 1'b1, 64'h7FFF_FFF8);
        set_rd(1, 1'b1, BASE + 64'(DEPTH) * 8);
        cycle();
        chk("oor low err", 64'(rd_err[0]), 64'd1);
        chk("oor high err", 64'(rd_err[1]), 64'd1);
        chk("oor high data", rd_data[DW +: DW], 64'd0);
        idle();
        set_wr(1'b1, BASE + 64'(DEPTH) * 8, 64'hCAFE_CAFE_CAFE_CAFE, 8'hFF);
        cycle();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            set_rd(0, 1'b1, BASE + 64'(i) * 8);
            set_rd(1, 1'b1, BASE + 64'(DEPTH - 1 - i) * 8);
            cycle();
        end
        idle();

        // Randomized traffic against the reference
        for (int n = 0; n < 300; n++) begin
            set_wr(1'($urandom_range(0, 9) < 4), rand_addr(), {$urandom, $urandom},
                   8'($urandom));
            for (int p = 0; p < NRD; p++) set_rd(p, 1'($urandom_range(0, 3) != 0), rand_addr());
            cycle();
        end
        idle();

        // Known word, then reads in flight, then asynchronous reset
        set_wr(1'b1, BASE + 64'd8, 64'h0123_4567_89AB_CDEF, 8'hFF);
        cycle();
        idle();
        set_rd(0, 1'b1, BASE + 64'd8);
        set_rd(1, 1'b1, BASE + 64'(DEPTH) * 8);
        cycle();
        rst = 1'b1;
        #1;
        chk("async rst ready", 64'(ready), 64'd0);
        chk("async rst rd_valid", 64'(rd_valid), 64'd0);
        chk("async rst rd_err", 64'(rd_err), 64'd0);
        chk("async rst rd_data0", rd_data[0 +: DW], 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (DEPTH) cycle();
        idle();
        set_rd(0, 1'b1, BASE + 64'd8);
        set_rd(1, 1'b1, BASE + 64'd16);
        cycle();
        chk("post rst word1", rd_data[0 +: DW], 64'd0);
        chk("post rst word2", rd_data[DW +: DW], 64'd0);
        idle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
